// File: rtl/mcu_block_scheduler_pkg.sv
// mcu_block_scheduler_pkg: shared constants, state type and width helper for the MCU block scheduler
package mcu_block_scheduler_pkg;
  localparam int BLOCK_LEN = 64;
  typedef enum logic [1:0] {IDLE, STREAM, DONE, GAP} sched_state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mcu_block_scheduler_order_gen.sv
// mcu_order_gen: maps a block index within an MCU to its component id and flags the last block
module mcu_order_gen
  import mcu_block_scheduler_pkg::*;
#(
  parameter int NUM_COMP = 3,
  parameter int Y_BLOCKS = 4,
  parameter int BW       = 3,
  parameter int CW       = 2
) (
  input  logic [BW-1:0] blk,
  output logic [CW-1:0] comp,
  output logic          last
);
  assign comp = (int'(blk) < Y_BLOCKS) ? '0 : CW'(int'(blk) - Y_BLOCKS + 1);
  assign last = int'(blk) == Y_BLOCKS + NUM_COMP - 2;
endmodule

// File: rtl/mcu_block_scheduler.sv
// mcu_block_scheduler: pulls 8x8 coefficient blocks from per-component requesters in MCU order
module mcu_block_scheduler
  import mcu_block_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = 10,
  parameter int NUM_COMP       = 3,
  parameter int Y_BLOCKS       = 4,
  parameter int MCUS_PER_FRAME = 1200,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  input  logic [NUM_COMP-1:0]             req_valid,
  input  logic [NUM_COMP*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_COMP-1:0]             req_ready,
  input  logic                            out_ready,
  output logic                            code_valid,
  output logic [DATA_WIDTH-1:0]           code_data,
  output logic                            code_done,
  output logic [clog2_min1(NUM_COMP)-1:0] code_comp,
  output logic                            mcu_done,
  output logic                            frame_done
);
  localparam int CW = clog2_min1(NUM_COMP);
  localparam int BW = clog2_min1(Y_BLOCKS + NUM_COMP - 1);
  localparam int MW = clog2_min1(MCUS_PER_FRAME);
  localparam int GW = clog2_min1(GAP_CYCLES + 1);
  sched_state_t  state, state_n;
  logic [5:0]    coef;
  logic [BW-1:0] blk;
  logic [MW-1:0] mcu;
  logic [GW-1:0] gap;
  logic [CW-1:0] sel;
  logic          fin, xfer, done_acc, last_blk, mcu_last, frame_last, gap_end;
  mcu_order_gen #(.NUM_COMP(NUM_COMP), .Y_BLOCKS(Y_BLOCKS), .BW(BW), .CW(CW)) u_order (
    .blk(blk), .comp(sel), .last(last_blk)
  );
  assign xfer       = (state == STREAM) && req_valid[sel] && out_ready;
  assign done_acc   = (state == DONE) && out_ready;
  assign mcu_last   = mcu == MW'(MCUS_PER_FRAME - 1);
  assign frame_last = last_blk && mcu_last;
  assign gap_end    = gap == GW'(GAP_CYCLES - 1);
  assign req_ready  = (state == STREAM) ? NUM_COMP'(out_ready) << sel : '0;
  // next-state: the frame-end flag decides where the gap leads
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? STREAM : IDLE;
      STREAM:  state_n = (xfer && coef == 6'(BLOCK_LEN - 1)) ? DONE : STREAM;
      DONE:    state_n = !out_ready ? DONE : (GAP_CYCLES > 0) ? GAP : frame_last ? IDLE : STREAM;
      GAP:     state_n = !gap_end ? GAP : fin ? IDLE : STREAM;
      default: state_n = IDLE;
    endcase
  end
  // state, coefficient/block/MCU/gap counters and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      coef  <= '0;
      blk   <= '0;
      mcu   <= '0;
      gap   <= '0;
      fin   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      gap   <= (state == GAP) ? gap + 1'b1 : '0;
      if (xfer) coef <= coef + 6'd1;
      if (done_acc) begin
        blk <= last_blk ? '0 : blk + 1'b1;
        fin <= frame_last;
        if (last_blk) mcu <= mcu_last ? '0 : mcu + 1'b1;
      end
      if (frame_done) busy <= 1'b0;
      if (state == IDLE && start) begin
        coef <= '0;
        blk  <= '0;
        mcu  <= '0;
        fin  <= 1'b0;
        busy <= 1'b1;
      end
    end
  end
  // registered output stage: strobe-only stream plus trailer pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_valid <= 1'b0;
      code_data  <= '0;
      code_done  <= 1'b0;
      code_comp  <= '0;
      mcu_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      code_valid <= xfer;
      code_done  <= done_acc;
      mcu_done   <= done_acc && last_blk;
      frame_done <= done_acc && frame_last;
      if (xfer) code_data <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
      if (xfer || done_acc) code_comp <= sel;
    end
  end
endmodule
